shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle shift engine that sits directly upstream of nBit_Shift and drives it.
- Accepts one operand with a shift request over a valid/ready handshake, then performs the shift as a series of single-bit steps, one per clock.
- Each step is executed by nBit_Shift instances with shift_amt fixed at 1.
- Returns the result over a valid/ready handshake. This gives a small-area sequential alternative to a full barrel shift for the ALU datapath.

Parameters:
- WIDTH, 4, data width in bits; must be ≥2.
- AMT_W, 4, width of the requested shift amount (same as WIDTH by default, matching the nBit_Shift shift_amt width).

Ports:
- clk  input  1  single system clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request.
- in_data  input  WIDTH  operand.
- in_dir  input  1  0 = shift left, 1 = shift right.
- in_op  input  1  0 = logical, 1 = arithmetic; affects right shifts only.
- in_amt  input  AMT_W  requested shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- States: IDLE, SHIFT, DONE. Encoding is 2 bits: IDLE=0, SHIFT=1, DONE=2. The unused code 3 returns to IDLE on the next edge.
- Reset (rst_n low, asynchronous):
  - state=IDLE; internal data_r, cnt, dir_r and op_r all cleared to 0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready=1, because it is decoded from IDLE.
  - Any in-flight transaction is dropped with no partial result.
- in_ready = (state==IDLE). out_valid = (state==DONE). out_data = data_r.
- out_data is 0 in IDLE and during reset; data_r is cleared on the DONE→IDLE transition.
- Accept on an edge where in_valid & in_ready:
  - data_r ← in_data; dir_r ← in_dir; op_r ← in_op.
  - cnt ← min(in_amt, WIDTH).
  - Next state is DONE if cnt is 0, otherwise SHIFT.
- SHIFT: each edge does data_r ← one-step shift of data_r and cnt ← cnt−1. When cnt==1 at the edge, the next state is DONE.
- One-step shift rules:
  - Left: data_r ← {data_r[WIDTH-2:0], 0}.
  - Right logical: data_r ← {0, data_r[WIDTH-1:1]}.
  - Right arithmetic: data_r ← {data_r[WIDTH-1], data_r[WIDTH-1:1]}.
- Latency:
  - Amount k with 1 ≤ k < WIDTH: out_valid rises after the k-th edge following the accept edge.
  - k=0: out_valid is visible in the cycle right after the accept edge.
  - k ≥ WIDTH: saturates to exactly WIDTH steps. The result is all zeros, except right-arithmetic, which gives all copies of the sign bit.
- DONE: out_data and out_valid hold stable until out_ready. The edge with out_valid & out_ready moves to IDLE.
- No back-to-back overlap: a new request can be accepted one cycle after the result handshake. Throughput is one result per min(k,WIDTH)+2 cycles.
- in_valid, in_data and in_amt are ignored outside IDLE. Changing them mid-operation does not affect the result.
- in_op is ignored when in_dir=0.
- Reset asserted mid-SHIFT or mid-DONE clears immediately, with no clock required.

Decomposition:
- Shared header shift_defs:
  - State codes ST_IDLE, ST_SHIFT, ST_DONE.
  - DIR_LEFT=0, DIR_RIGHT=1.
  - OP_LOGICAL=0, OP_ARITH=1.
- Sub-modules: two existing nBit_Shift instances, both WIDTH=WIDTH and shift_amt tied to 1.
  - One with OP=0 (logical), one with OP=1 (arithmetic).
  - Both take data_r and dir_r as inputs.
  - The step result is muxed by op_r.
- The FSM, counter and handshake live in shift_sequencer itself.

Test Plan (WIDTH=4):
- Left logical, in_data=0011, amt=2 → out_data=1100; out_valid after 2 edges post-accept; busy high throughout.
- Right, in_data=1000, amt=2 → out_data=1110 with op=1, and 0010 with op=0.
- amt=0, in_data=1011, dir=1, op=1 → out_data=1011; out_valid in the cycle after accept.
- amt=7 (saturation):
  - Right arithmetic, in_data=1001 → 1111 after exactly 4 SHIFT edges.
  - Same request with left shift → 0000 after 4 edges.
- Backpressure:
  - Setup: result ready, out_ready held low for 5 cycles while in_valid=1 with in_data=0101.
  - Expected: out_data stable, in_ready=0, the new request is not taken. After out_ready=1, IDLE follows, then the 0101 request is accepted.
- Reset: rst_n pulled low mid-SHIFT, between clock edges → out_valid=0, out_data=0, busy=0 immediately, in_ready=1. After release, a fresh request completes correctly.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the sequential shift engine.
//   state_t            : FSM state codes (2-bit; code 3 is unused and recovers to IDLE)
//   DIR_LEFT/DIR_RIGHT : shift direction encoding of in_dir / dir
//   OP_LOGICAL/OP_ARITH: right-shift fill encoding of in_op / OP
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT   = 1'b0;
  localparam logic DIR_RIGHT  = 1'b1;
  localparam logic OP_LOGICAL = 1'b0;
  localparam logic OP_ARITH   = 1'b1;

endpackage

// File: rtl/nBit_Shift.sv
// Combinational n-bit shifter used as the single-step datapath of the
// sequencer.
//   data      : operand
//   dir       : DIR_LEFT / DIR_RIGHT
//   shift_amt : shift distance (the sequencer ties this to 1)
//   result    : shifted operand; OP selects logical or arithmetic right fill,
//               left shifts always fill with zero
module nBit_Shift
  import shift_sequencer_pkg::*;
#(
  parameter int   WIDTH = 4,
  parameter logic OP    = OP_LOGICAL
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic [WIDTH-1:0] shift_amt,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    if (dir == DIR_LEFT) begin
      result = data << shift_amt;
    end else if (OP == OP_ARITH) begin
      result = WIDTH'($signed(data) >>> shift_amt);
    end else begin
      result = data >> shift_amt;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: accepts one operand + shift request, performs
// the shift one bit per clock through two nBit_Shift instances, and returns
// the result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and out_data holds stable there until out_ready is seen.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : request handshake
//   in_data, in_dir, in_op : operand, direction (0 left), fill (1 arithmetic)
//   in_amt                 : requested amount, saturated to WIDTH
//   out_valid/out_ready    : result handshake
//   out_data               : result (0 while IDLE)
//   busy                   : high in SHIFT or DONE
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // Counter must hold the saturated value WIDTH itself.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt;
  logic             dir_r;
  logic             op_r;

  logic             accept;
  logic [CNT_W-1:0] amt_sat;
  logic [WIDTH-1:0] step_logical;
  logic [WIDTH-1:0] step_arith;
  logic [WIDTH-1:0] step;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_SHIFT) || (state == ST_DONE);
  assign out_data  = data_r;
  assign accept    = in_valid && in_ready;

  // Anything at or beyond WIDTH gives the same result as exactly WIDTH steps.
  always_comb begin
    if (int'(in_amt) >= WIDTH) begin
      amt_sat = CNT_W'(WIDTH);
    end else begin
      amt_sat = CNT_W'(in_amt);
    end
  end

  nBit_Shift #(.WIDTH(WIDTH), .OP(OP_LOGICAL)) u_step_logical (
    .data      (data_r),
    .dir       (dir_r),
    .shift_amt (STEP_ONE),
    .result    (step_logical)
  );

  nBit_Shift #(.WIDTH(WIDTH), .OP(OP_ARITH)) u_step_arith (
    .data      (data_r),
    .dir       (dir_r),
    .shift_amt (STEP_ONE),
    .result    (step_arith)
  );

  // For left shifts both instances agree, so op_r only matters going right.
  assign step = (op_r == OP_ARITH) ? step_arith : step_logical;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = (amt_sat == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      cnt    <= '0;
      dir_r  <= 1'b0;
      op_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_r <= in_data;
            cnt    <= amt_sat;
            dir_r  <= in_dir;
            op_r   <= in_op;
          end
        end
        ST_SHIFT: begin
          data_r <= step;
          cnt    <= cnt - CNT_W'(1);
        end
        ST_DONE: begin
          // Returning to IDLE leaves out_data at zero.
          if (out_ready) begin
            data_r <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         in_op;
  logic [3:0]   in_amt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];

  shift_sequencer #(.WIDTH(W), .AMT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Shift by k = min(amt, W) expressed as multiply / floor-divide by 2**k.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dir,
                                         input logic op, input int amt);
    int k;
    int p;
    int v;
    int q;
    k = (amt > W) ? W : amt;
    p = 1 << k;
    v = int'(d);
    if (!dir) begin
      q = (v * p) % (1 << W);
    end else if (op && d[W-1]) begin
      v = v - (1 << W);
      q = -((-v + p - 1) / p);
      q = ((q % (1 << W)) + (1 << W)) % (1 << W);
    end else begin
      q = v / p;
    end
    return W'(q);
  endfunction

  // ---------------- driver ----------------
  // Drives one request, waits for the result (bounded), holds out_ready low
  // for ready_delay cycles, then completes the result handshake.
  task automatic run_txn(input logic [W-1:0] d, input logic dir, input logic op,
                         input logic [3:0] amt, input int ready_delay,
                         output logic [W-1:0] res, output int lat,
                         output logic busy_ok, output logic stable_ok,
                         output logic timeout, output logic idle_ok);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_op    = op;
    in_amt   = amt;
    @(posedge clk);
    @(negedge clk);
    // Scramble ignored inputs after the accept edge.
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_amt   = 4'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 64) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    timeout = !out_valid;
    if (!busy) busy_ok = 1'b0;
    res       = out_data;
    stable_ok = 1'b1;
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      if (out_data !== res || !out_valid || in_ready) stable_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    idle_ok = in_ready && !out_valid && !busy && (out_data == '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    in_op     = 1'b0;
    in_amt    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%b, want 1 0 0 0000",
               in_ready, out_valid, busy, out_data);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] d_tab[6]   = '{4'b0011, 4'b1000, 4'b1000, 4'b1011, 4'b1001, 4'b1001};
    logic         dir_tab[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         op_tab[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]   amt_tab[6] = '{4'd2, 4'd2, 4'd2, 4'd0, 4'd7, 4'd7};
    logic [W-1:0] want_tab[6] = '{4'b1100, 4'b1110, 4'b0010, 4'b1011, 4'b1111, 4'b0000};
    int           lat_tab[6] = '{2, 2, 2, 0, 4, 4};
    logic [W-1:0] res;
    int           lat;
    logic         busy_ok, stable_ok, timeout, idle_ok;
    for (int i = 0; i < 6; i++) begin
      run_txn(d_tab[i], dir_tab[i], op_tab[i], amt_tab[i], 0,
              res, lat, busy_ok, stable_ok, timeout, idle_ok);
      checks++;
      if (timeout || res !== want_tab[i]) begin
        failures++;
        $display("FAIL directed_data[%0d]: got %b timeout=%b, want %b", i, res, timeout, want_tab[i]);
      end
      checks++;
      if (lat != lat_tab[i]) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, lat_tab[i]);
      end
      checks++;
      if (!busy_ok || !idle_ok) begin
        failures++;
        $display("FAIL directed_busy_idle[%0d]: busy_ok=%b idle_ok=%b, want 1 1", i, busy_ok, idle_ok);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    int           n;
    // First request: 0011 left by 1 -> 0110.
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b0011; in_dir = 1'b0; in_op = 1'b0; in_amt = 4'd1;
    @(posedge clk);
    @(negedge clk);
    in_data = 4'b0101; in_amt = 4'd1;  // pending second request, kept valid
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    held = out_data;
    checks++;
    if (!out_valid || held !== 4'b0110) begin
      failures++;
      $display("FAIL bp_first_result: valid=%b data=%b, want 1 0110", out_valid, held);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_data !== 4'b0110 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: data=%b in_ready=%b out_valid=%b, want 0110 0 1",
                 i, out_data, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle_after: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk);  // 0101 request accepted here
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid || out_data !== model(4'b0101, 1'b0, 1'b0, 1)) begin
      failures++;
      $display("FAIL bp_second_result: valid=%b data=%b, want 1 %b",
               out_valid, out_data, model(4'b0101, 1'b0, 1'b0, 1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] res;
    int           lat;
    logic         busy_ok, stable_ok, timeout, idle_ok;
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1101; in_dir = 1'b1; in_op = 1'b1; in_amt = 4'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_shift: out_valid=%b out_data=%b busy=%b in_ready=%b, want 0 0000 0 1",
               out_valid, out_data, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(4'b0110, 1'b1, 1'b0, 4'd1, 1, res, lat, busy_ok, stable_ok, timeout, idle_ok);
    checks++;
    if (timeout || res !== 4'b0011 || lat != 1) begin
      failures++;
      $display("FAIL reset_recover: got %b lat=%0d, want 0011 lat=1", res, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d, res, want;
    logic         dir, op;
    logic [3:0]   amt;
    int           lat, want_lat;
    logic         busy_ok, stable_ok, timeout, idle_ok;
    for (int i = 0; i < 40; i++) begin
      d   = W'($urandom);
      dir = 1'($urandom);
      op  = 1'($urandom);
      amt = 4'($urandom_range(0, 15));
      exp_q.push_back(model(d, dir, op, int'(amt)));
      want_lat = (int'(amt) > W) ? W : int'(amt);
      run_txn(d, dir, op, amt, $urandom_range(0, 3), res, lat, busy_ok, stable_ok, timeout, idle_ok);
      want = exp_q.pop_front();
      checks++;
      if (timeout || res !== want || lat != want_lat || !stable_ok || !busy_ok || !idle_ok) begin
        failures++;
        $display("FAIL random[%0d] d=%b dir=%b op=%b amt=%0d: got %b lat=%0d stable=%b busy=%b idle=%b, want %b lat=%0d",
                 i, d, dir, op, amt, res, lat, stable_ok, busy_ok, idle_ok, want, want_lat);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
